// File: rtl/rs_enc_ctrl.sv
// rs_enc_ctrl: sequencer for a systematic RS(N,K) encoder that is built from a
// free-running GF(2^8) constant-multiply stage chain (r_k <= r_(k-1) ^ g_k*mr).
// The block accepts K message symbols and passes them through. It drives the
// chain feedback mr, then shifts NPAR parity symbols out of the last stage.
// Zero feedback during the parity shift leaves the chain clean for the next
// codeword.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active low
//   in_valid   message symbol valid
//   in_ready   a symbol is accepted this cycle (combinational)
//   in_data    message symbol
//   r_last     register of the last chain stage
//   mr         feedback into every chain stage (combinational)
//   out_valid  codeword symbol valid (registered)
//   out_data   codeword symbol (registered)
//   out_sop    first symbol of the codeword
//   out_eop    last parity symbol
//   out_par    out_data is a parity symbol
//   abort      one-cycle pulse: message underrun, codeword dropped
module rs_enc_ctrl #(
  parameter int unsigned K    = 239,
  parameter int unsigned NPAR = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] r_last,
  output logic [7:0] mr,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_par,
  output logic       abort
);

  localparam int unsigned CNT_MAX = (K > NPAR + 1) ? K : NPAR + 1;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_KM1 = CW'(K - 1);
  localparam logic [CW-1:0] C_NM1 = CW'(NPAR - 1);
  localparam logic [CW-1:0] C_N   = CW'(NPAR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MSG,
    S_PAR,
    S_CLR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic       w_valid_nxt;
  logic [7:0] w_data_nxt;
  logic       w_sop_nxt;
  logic       w_eop_nxt;
  logic       w_par_nxt;
  logic       w_abort_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_par   <= 1'b0;
      abort     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      out_valid <= w_valid_nxt;
      out_data  <= w_data_nxt;
      out_sop   <= w_sop_nxt;
      out_eop   <= w_eop_nxt;
      out_par   <= w_par_nxt;
      abort     <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    mr          = '0;
    w_valid_nxt = 1'b0;
    w_data_nxt  = '0;
    w_sop_nxt   = 1'b0;
    w_eop_nxt   = 1'b0;
    w_par_nxt   = 1'b0;
    w_abort_nxt = 1'b0;

    // While reset is held everything stays at its default (ready low, mr zero).
    if (rst) begin
      case (r_state)
        S_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            mr          = in_data ^ r_last;
            w_valid_nxt = 1'b1;
            w_data_nxt  = in_data;
            w_sop_nxt   = 1'b1;
            if (K == 1) begin
              w_state_nxt = S_PAR;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_MSG;
              w_cnt_nxt   = CW'(1);
            end
          end
        end

        S_MSG: begin
          in_ready = 1'b1;
          if (in_valid) begin
            mr          = in_data ^ r_last;
            w_valid_nxt = 1'b1;
            w_data_nxt  = in_data;
            if (r_cnt == C_KM1) begin
              w_state_nxt = S_PAR;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else begin
            // Symbols must arrive back-to-back; a gap drops the codeword and
            // the chain is flushed before the next one is accepted.
            w_abort_nxt = 1'b1;
            w_state_nxt = S_CLR;
            w_cnt_nxt   = '0;
          end
        end

        S_PAR: begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = r_last;
          w_par_nxt   = 1'b1;
          if (r_cnt == C_NM1) begin
            w_eop_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end

        S_CLR: begin
          // NPAR+1 zero-feedback cycles also drain the chain's g pipeline.
          if (r_cnt == C_N) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_enc_ctrl.sv
// Self-checking bench for rs_enc_ctrl. Two instances: K=239/NPAR=16 with an
// attached GF(2^8) stage chain (checked against an RS(255,239) long-division
// model), and K=1/NPAR=2 exercised from a cycle-by-cycle vector table.
module tb_rs_enc_ctrl;

  localparam int unsigned KA = 239;
  localparam int unsigned NA = 16;
  localparam int unsigned KB = 1;
  localparam int unsigned NB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, ivA, rdyA, vA, sopA, eopA, parA, abA;
  logic [7:0] dA, rlastA, mrA, odA;
  logic       rstB, ivB, rdyB, vB, sopB, eopB, parB, abB;
  logic [7:0] dB, rlastB, mrB, odB;

  rs_enc_ctrl #(.K(KA), .NPAR(NA)) u_dut_a (
    .clk(clk), .rst(rstA), .in_valid(ivA), .in_ready(rdyA), .in_data(dA),
    .r_last(rlastA), .mr(mrA), .out_valid(vA), .out_data(odA),
    .out_sop(sopA), .out_eop(eopA), .out_par(parA), .abort(abA)
  );

  rs_enc_ctrl #(.K(KB), .NPAR(NB)) u_dut_b (
    .clk(clk), .rst(rstB), .in_valid(ivB), .in_ready(rdyB), .in_data(dB),
    .r_last(rlastB), .mr(mrB), .out_valid(vB), .out_data(odB),
    .out_sop(sopB), .out_eop(eopB), .out_par(parB), .abort(abB)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  logic [7:0] gA [0:NA];
  logic [7:0] gB [0:NB];
  logic [7:0] gtmp [0:64];

  // g(x) = prod (x + a^i), i = 0..n-1, coefficients indexed by degree
  task automatic build_gen(input int n);
    logic [7:0] root;
    for (int j = 0; j <= 64; j++) gtmp[j] = '0;
    gtmp[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j >= 1; j--) gtmp[j] = gtmp[j-1] ^ gf_mul(root, gtmp[j]);
      gtmp[0] = gf_mul(root, gtmp[0]);
      root = gf_mul(root, 8'h02);
    end
  endtask

  // Stage chains attached to each controller; cleared by the system reset.
  logic [7:0] chA [0:NA-1];
  logic [7:0] chB [0:NB-1];
  always @(posedge clk) begin
    if (!rstA) begin
      for (int k = 0; k < NA; k++) chA[k] <= '0;
    end else begin
      chA[0] <= gf_mul(gA[0], mrA);
      for (int k = 1; k < NA; k++) chA[k] <= chA[k-1] ^ gf_mul(gA[k], mrA);
    end
  end
  always @(posedge clk) begin
    if (!rstB) begin
      for (int k = 0; k < NB; k++) chB[k] <= '0;
    end else begin
      chB[0] <= gf_mul(gB[0], mrB);
      for (int k = 1; k < NB; k++) chB[k] <= chB[k-1] ^ gf_mul(gB[k], mrB);
    end
  end
  assign rlastA = chA[NA-1];
  assign rlastB = chB[NB-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor for instance A: {sop, eop, par, data} per valid cycle.
  int          cyc = 0;
  logic [10:0] cap [$];
  int          capc [$];
  int          n_abort = 0;
  int          n_rdy_low = 0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (vA === 1'b1) begin
      cap.push_back({sopA, eopA, parA, odA});
      capc.push_back(cyc);
    end
    if (abA === 1'b1) n_abort++;
  end
  always @(negedge clk) begin
    #3;
    if (rstA === 1'b1 && rdyA === 1'b0) n_rdy_low++;
  end

  logic [7:0]  msg [0:KA-1];
  logic [10:0] expq [$];

  // Expected stream: message pass-through, then the remainder of m(x)*x^NA / g(x)
  task automatic push_cw(input int n, input bit full);
    logic [7:0] cw [0:KA+NA-1];
    logic [7:0] coef;
    for (int i = 0; i < n; i++) expq.push_back({(i == 0), 2'b00, msg[i]});
    if (full) begin
      for (int i = 0; i < KA + NA; i++) cw[i] = (i < KA) ? msg[i] : 8'h00;
      for (int i = 0; i < KA; i++) begin
        coef = cw[i];
        for (int j = 1; j <= NA; j++) cw[i+j] = cw[i+j] ^ gf_mul(coef, gA[NA-j]);
      end
      for (int j = 0; j < NA; j++) expq.push_back({1'b0, (j == NA - 1), 1'b1, cw[KA+j]});
    end
  endtask

  // Called on a negedge; returns on a negedge.
  task automatic drive(input int n, input bit hold);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      ivA = 1'b1;
      dA  = msg[i];
      #1;
      while (rdyA !== 1'b1 && guard < 100) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 100) begin
        errors++;
        $display("FAIL drive_timeout actual=%0d required=<100", guard);
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!hold) ivA = 1'b0;
  endtask

  task automatic cmp(input string tag);
    int n;
    chk({tag, "_len"}, cap.size(), expq.size());
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_sym%0d", tag, i), {21'd0, cap[i]}, {21'd0, expq[i]});
      if (i > 0 && expq[i][10] == 1'b0)
        chk($sformatf("%s_gap%0d", tag, i), capc[i] - capc[i-1], 1);
    end
    cap.delete();
    capc.delete();
    expq.delete();
  endtask

  typedef struct packed {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic [7:0] mr;
    logic       v;
    logic [7:0] od;
    logic       sop;
    logic       eop;
    logic       par;
    logic       ab;
  } vec_t;

  vec_t tv [0:13];
  int   c0;

  initial begin
    tv[0]  = '{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b1, 8'h55, 1'b1, 8'h55, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    build_gen(NA);
    for (int j = 0; j <= NA; j++) gA[j] = gtmp[j];
    build_gen(NB);
    for (int j = 0; j <= NB; j++) gB[j] = gtmp[j];

    rstA = 1'b0; ivA = 1'b1; dA = 8'h00;
    rstB = 1'b0; ivB = 1'b0; dB = 8'h00;

    // T1: reset held 3 clk with in_valid high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("T1_outs_%0d", i), {vA, odA, sopA, eopA, parA, abA}, 0);
      chk($sformatf("T1_ready_%0d", i), rdyA, 0);
      chk($sformatf("T1_mr_%0d", i), mrA, 0);
    end
    @(negedge clk);
    rstA = 1'b1;
    c0 = cyc;
    #1;
    chk("T1_ready_after_rst", rdyA, 1);

    // T2: all-zero message
    for (int i = 0; i < KA; i++) msg[i] = 8'h00;
    push_cw(KA, 1'b1);
    drive(KA, 1'b0);
    repeat (NA + 3) @(negedge clk);
    chk("T1_first_xfer_seen", cap.size() > 0, 1);
    if (cap.size() > 0) chk("T1_first_xfer_cycle", capc[0], c0 + 1);
    cmp("T2");

    // T3: message 1..239
    for (int i = 0; i < KA; i++) msg[i] = 8'(i + 1);
    push_cw(KA, 1'b1);
    drive(KA, 1'b0);
    repeat (NA + 3) @(negedge clk);
    cmp("T3");

    // T4: two codewords, in_valid continuous
    n_rdy_low = 0;
    for (int i = 0; i < KA; i++) msg[i] = 8'(i * 7 + 3);
    push_cw(KA, 1'b1);
    drive(KA, 1'b1);
    for (int i = 0; i < KA; i++) msg[i] = 8'(255 - i);
    push_cw(KA, 1'b1);
    drive(KA, 1'b0);
    repeat (NA + 3) @(negedge clk);
    chk("T4_ready_low", n_rdy_low, 2 * NA);
    if (cap.size() >= 2 * (KA + NA))
      chk("T4_spacing", capc[KA+NA] - capc[KA+NA-1], 1);
    cmp("T4");

    // T5: underrun after symbol 100, then a full codeword
    n_abort = 0;
    n_rdy_low = 0;
    for (int i = 0; i < KA; i++) msg[i] = 8'(i * 13 + 5);
    push_cw(101, 1'b0);
    drive(101, 1'b0);
    repeat (NA + 6) @(negedge clk);
    chk("T5_abort_cycles", n_abort, 1);
    chk("T5_clr_cycles", n_rdy_low, NA + 1);
    cmp("T5_abort");
    for (int i = 0; i < KA; i++) msg[i] = 8'(i) ^ 8'hA5;
    push_cw(KA, 1'b1);
    drive(KA, 1'b0);
    repeat (NA + 3) @(negedge clk);
    chk("T5_abort_after", n_abort, 1);
    cmp("T5_next");

    // T6: K=1 NPAR=2 vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rstB = tv[i].rst;
      ivB  = tv[i].iv;
      dB   = tv[i].d;
      #1;
      chk($sformatf("T6_ready_%0d", i), rdyB, tv[i].rdy);
      chk($sformatf("T6_mr_%0d", i), mrB, tv[i].mr);
      @(posedge clk);
      #1;
      chk($sformatf("T6_flags_%0d", i), {vB, sopB, eopB, parB, abB},
          {tv[i].v, tv[i].sop, tv[i].eop, tv[i].par, tv[i].ab});
      if (tv[i].v || !tv[i].rst) chk($sformatf("T6_data_%0d", i), odB, tv[i].od);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
